// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the off-chip SRAM controller: FSM encoding, SRAM bus
// widths, default data-memory base and the byte-address to SRAM-word mapping.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int SRAM_ADDR_W         = 18;
  localparam int SRAM_DATA_W         = 16;
  localparam int WORD_IDX_W          = SRAM_ADDR_W - 1;
  localparam int DEFAULT_ADDR_OFFSET = 1024;

  // Out-of-range addresses wrap silently modulo the SRAM word count.
  function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] byte_addr,
                                                       input int          offset);
    return WORD_IDX_W'((byte_addr - 32'(offset)) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// 32-bit load/store to two 16-bit SRAM accesses; 2*WAIT_CYCLES+3 cycles busy per word.
// ready is low while busy (pipeline freezes), high in IDLE-without-request and DONE.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_OFFSET = DEFAULT_ADDR_OFFSET
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   op_wr;
  logic [WORD_IDX_W-1:0]  word_q;
  logic [SRAM_DATA_W-1:0] wdata_hi_q;
  logic [SRAM_DATA_W-1:0] dq_out;
  logic                   dq_oe;
  logic                   req;
  logic [WORD_IDX_W-1:0]  word_idx;

  assign req      = wr_en | rd_en;
  assign word_idx = word_index(address, ADDR_OFFSET);

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign ready = rst | (state == ST_DONE) | ((state == ST_IDLE) & ~req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      word_q     <= '0;
      wdata_hi_q <= '0;
      read_data  <= '0;
      SRAM_ADDR  <= '0;
      SRAM_WE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_CE_N  <= 1'b1;
      dq_oe      <= 1'b0;
      dq_out     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            // A simultaneous read is dropped: the store wins.
            state      <= ST_LO;
            cnt        <= CNT_LOAD;
            op_wr      <= wr_en;
            word_q     <= word_idx;
            wdata_hi_q <= write_data[31:16];
            SRAM_ADDR  <= {word_idx, 1'b0};
            SRAM_CE_N  <= 1'b0;
            SRAM_WE_N  <= ~wr_en;
            SRAM_OE_N  <= wr_en;
            dq_oe      <= wr_en;
            dq_out     <= write_data[15:0];
          end
        end
        ST_LO: begin
          if (cnt == '0) begin
            state     <= ST_HI;
            cnt       <= CNT_LOAD;
            SRAM_ADDR <= {word_q, 1'b1};
            dq_out    <= wdata_hi_q;
            if (!op_wr) read_data[15:0] <= SRAM_DQ;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HI: begin
          if (cnt == '0) begin
            state     <= ST_DONE;
            SRAM_CE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_oe     <= 1'b0;
            if (!op_wr) read_data[31:16] <= SRAM_DQ;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboarded bench: two controllers (WAIT_CYCLES=1 and 0), each on its own SRAM model,
// driven by directed and random loads/stores checked against a word-level memory model.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en0, rd_en0, wr_en1, rd_en1;
  logic [31:0] address, write_data;
  logic [31:0] read_data0, read_data1;
  logic        ready0, ready1;
  wire  [15:0] dq0, dq1;
  logic [17:0] sa0, sa1;
  logic        we_n0, oe_n0, ce_n0, ub_n0, lb_n0;
  logic        we_n1, oe_n1, ce_n1, ub_n1, lb_n1;

  logic [15:0] mem0 [262144];
  logic [15:0] mem1 [262144];

  sram_controller #(.WAIT_CYCLES(1), .ADDR_OFFSET(1024)) u_w1 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address),
    .write_data(write_data), .read_data(read_data0), .ready(ready0), .SRAM_DQ(dq0),
    .SRAM_ADDR(sa0), .SRAM_WE_N(we_n0), .SRAM_OE_N(oe_n0), .SRAM_CE_N(ce_n0),
    .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0)
  );

  sram_controller #(.WAIT_CYCLES(0), .ADDR_OFFSET(1024)) u_w0 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address),
    .write_data(write_data), .read_data(read_data1), .ready(ready1), .SRAM_DQ(dq1),
    .SRAM_ADDR(sa1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1), .SRAM_CE_N(ce_n1),
    .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1)
  );

  // Board SRAM models: asynchronous read while OE_N low, store on any edge with WE_N low.
  assign dq0 = (!ce_n0 && !oe_n0 && we_n0) ? mem0[sa0] : 16'hzzzz;
  assign dq1 = (!ce_n1 && !oe_n1 && we_n1) ? mem1[sa1] : 16'hzzzz;
  always @(posedge clk) if (!ce_n0 && !we_n0) mem0[sa0] <= dq0;
  always @(posedge clk) if (!ce_n1 && !we_n1) mem1[sa1] <= dq1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        inst;
    logic        wr;
    logic [16:0] w;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          mcnt[2];
  bit          mon_en = 1'b0;
  logic [31:0] refm[int];
  logic [31:0] wl0[$];
  logic [31:0] wl1[$];
  logic [31:0] last_rd[2];

  function automatic logic [16:0] widx(input logic [31:0] a);
    logic [31:0] d;
    d = {a[31:2], 2'b00} - 32'd1024;
    return d[18:2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int i, input logic req, input logic rdy, input logic ce,
                     input logic we, input logic oe, input logic ub, input logic lb,
                     input logic [17:0] sa, input logic [31:0] rd);
    int   wc;
    exp_t e;
    wc = (i == 0) ? 1 : 0;
    if (!req) begin
      chk("idle_ready", 32'(rdy), 32'd1);
      chk("idle_ce_n", 32'(ce), 32'd1);
      mcnt[i] = 0;
      return;
    end
    if (exp_q.size() == 0) begin
      chk("no_expected_entry", 32'd0, 32'd1);
      return;
    end
    e = exp_q[0];
    if (!rdy) begin
      if (mcnt[i] == 0) begin
        chk("req_cycle_ce_n", 32'(ce), 32'd1);
      end else if (mcnt[i] <= 2 * wc + 2) begin
        chk("ce_n", 32'(ce), 32'd0);
        chk("we_n", 32'(we), 32'(!e.wr));
        chk("oe_n", 32'(oe), 32'(e.wr));
        chk("sram_addr", 32'(sa), 32'({e.w, (mcnt[i] > wc + 1)}));
        chk("ub_lb_n", 32'({ub, lb}), 32'd0);
      end else begin
        chk("busy_too_long", 32'(mcnt[i]), 32'(2 * wc + 2));
      end
      mcnt[i]++;
    end else begin
      chk("ready_latency", 32'(mcnt[i]), 32'(2 * wc + 3));
      chk("read_data", rd, e.rd);
      chk("done_strobes", 32'({ce, we, oe}), 32'b111);
      chk("scoreboard_inst", 32'(e.inst), 32'(i));
      void'(exp_q.pop_front());
      mcnt[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, wr_en0 | rd_en0, ready0, ce_n0, we_n0, oe_n0, ub_n0, lb_n0, sa0, read_data0);
      mon(1, wr_en1 | rd_en1, ready1, ce_n1, we_n1, oe_n1, ub_n1, lb_n1, sa1, read_data1);
    end else begin
      mcnt[0] = 0;
      mcnt[1] = 0;
    end
  end

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic do_op(input int i, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input int gap);
    exp_t e;
    int   key;
    bit   done;
    key    = i * (1 << 17) + int'(widx(a));
    e.inst = i[0];
    e.wr   = wr;
    e.w    = widx(a);
    if (wr) begin
      refm[key] = d;
      e.rd      = last_rd[i];
      if (i == 0) wl0.push_back(a);
      else        wl1.push_back(a);
    end else begin
      e.rd       = refm.exists(key) ? refm[key] : 32'h0;
      last_rd[i] = e.rd;
    end
    exp_q.push_back(e);
    address    = a;
    write_data = d;
    if (i == 0) begin wr_en0 = wr; rd_en0 = rd; end
    else        begin wr_en1 = wr; rd_en1 = rd; end
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = (i == 0) ? ready0 : ready1;
    end
    if (!done) begin
      chk("op_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    wr_en0 = 1'b0; rd_en0 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_op(input int i);
    int          r, sz;
    logic [31:0] a;
    r  = $urandom_range(0, 9);
    sz = (i == 0) ? wl0.size() : wl1.size();
    if (r < 4 && sz > 0) begin
      if (i == 0) a = wl0[$urandom_range(0, sz - 1)];
      else        a = wl1[$urandom_range(0, sz - 1)];
      a = {a[31:2], 2'(unsigned'($urandom_range(0, 3)))};
      do_op(i, 1'b0, 1'b1, a, $urandom, $urandom_range(0, 2));
    end else begin
      if (r == 4) a = 32'd1024 - 32'd4 * 32'($urandom_range(1, 3));
      else        a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 15));
      a = a | 32'($urandom_range(0, 3));
      do_op(i, 1'b1, (r == 5), a, $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en0 = 1'b0; rd_en0 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0;
    address = '0; write_data = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    mcnt[0] = 0; mcnt[1] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready0", 32'(ready0), 32'd1);
    chk("reset_strobes0", 32'({we_n0, oe_n0, ce_n0}), 32'b111);
    chk("reset_addr0", 32'(sa0), 32'd0);
    chk("reset_read_data0", read_data0, 32'd0);
    chk("reset_strobes1", 32'({we_n1, oe_n1, ce_n1}), 32'b111);
    chk("reset_read_data1", read_data1, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    do_op(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 0);
    chk("mem_lo_w0", 32'(mem0[0]), 32'h0000BEEF);
    chk("mem_hi_w0", 32'(mem0[1]), 32'h0000DEAD);
    do_op(0, 1'b0, 1'b1, 32'd1024, 32'h0, 0);
    do_op(0, 1'b1, 1'b0, 32'd1028, 32'h12345678, 0);
    do_op(0, 1'b0, 1'b1, 32'd1028, 32'h0, 1);
    chk("mem_lo_w1", 32'(mem0[2]), 32'h00005678);
    chk("mem_hi_w1", 32'(mem0[3]), 32'h00001234);
    do_op(0, 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 1);
    chk("mem_lo_w2", 32'(mem0[4]), 32'h0000A5A5);
    chk("mem_hi_w2", 32'(mem0[5]), 32'h0000A5A5);

    // Reset in the first HI cycle of a store: the access is abandoned.
    mon_en     = 1'b0;
    address    = 32'd1040;
    write_data = 32'h0BADF00D;
    wr_en0     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_forces_ready", 32'(ready0), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    wr_en0 = 1'b0;
    @(negedge clk);
    chk("abort_strobes", 32'({we_n0, oe_n0, ce_n0}), 32'b111);
    chk("abort_ready", 32'(ready0), 32'd1);
    chk("abort_read_data", read_data0, 32'd0);
    chk("abort_addr", 32'(sa0), 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_op(0, 1'b0, 1'b1, 32'd1024, 32'h0, 0);

    for (int n = 0; n < 40; n++) rand_op(0);

    do_op(1, 1'b1, 1'b0, 32'd1024, 32'hC0FFEE11, 0);
    do_op(1, 1'b0, 1'b1, 32'd1024, 32'h0, 0);
    for (int n = 0; n < 25; n++) rand_op(1);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Off-chip SRAM controller directly downstream of the MEM stage. It turns single-cycle 32-bit load/store requests into two sequential 16-bit accesses on the board SRAM with programmable wait states. While an access is in flight it drives `ready` low, and the pipeline uses that to freeze. Word addresses are rebased by a fixed data-memory offset before reaching the SRAM.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles held per 16-bit half-access; ≥0.
- `ADDR_OFFSET`, default 1024: byte address mapped to SRAM word 0.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  store request; held stable by the frozen pipeline until `ready`.
- `rd_en`  in  1  load request; same hold rule.
- `address`  in  32  byte address, word aligned; bits [1:0] ignored.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result, registered.
- `ready`  out  1  0 = request in flight, pipeline must freeze.
- `SRAM_DQ`  inout  16  data bus; driven only during write phases, else high-Z.
- `SRAM_ADDR`  out  18  half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`  out  1 each  active-low strobes.
- `SRAM_UB_N`, `SRAM_LB_N`  out  1 each  tied 0 (both byte lanes always enabled).

## Operation
- Word index `w = (address - ADDR_OFFSET) >> 2`, truncated to 17 bits. No range check; out-of-range addresses wrap modulo 2^17.
- Low half is at `SRAM_ADDR = {w,1'b0}`, high half at `{w,1'b1}`.
- States: IDLE, LO, HI, DONE.
- IDLE: if `wr_en|rd_en`, latch the op, enter LO, load the wait counter with `WAIT_CYCLES`. Otherwise stay.
- `wr_en` and `rd_en` both high: the access is a write and the read is dropped. `read_data` is unchanged.
- LO / HI: each lasts `WAIT_CYCLES+1` cycles. The counter decrements and the state advances when it reaches 0. HI reloads the counter.
- During LO / HI:
  - `SRAM_CE_N=0`; `SRAM_ADDR` is stable for the whole phase.
  - Write: `SRAM_WE_N=0`, `SRAM_OE_N=1`, DQ driven with `write_data[15:0]` (LO) or `write_data[31:16]` (HI).
  - Read: `SRAM_OE_N=0`, `SRAM_WE_N=1`, DQ high-Z. DQ is sampled on the edge that ends the phase, into `read_data[15:0]` (LO) or `read_data[31:16]` (HI).
- DONE: strobes inactive, `ready=1` for exactly one cycle, then IDLE.
- `ready = !(state==DONE) && !(state==IDLE && !(wr_en|rd_en)) ? 0 : 1` (combinational). It is 1 in IDLE with no request and in DONE; 0 otherwise. It drops in the same cycle a request appears.
- `read_data` holds its last completed load value across writes and idle cycles.
- Reset (any state, including mid-access), on the next edge:
  - state IDLE, `read_data=0`, `SRAM_ADDR=0`.
  - `WE_N`, `OE_N`, `CE_N` = 1; DQ high-Z.
  - The interrupted access is abandoned; a partially written word is not repaired.
- While `rst=1`, `ready` is forced to 1.

## Timing
- Request first high in cycle 0, sampled in IDLE.
- LO occupies cycles 1..W+1 and HI occupies cycles W+2..2W+2, where W=`WAIT_CYCLES`.
- DONE is cycle 2W+3. `ready` is low in cycles 0..2W+2 and high in cycle 2W+3; full `read_data` is valid in that cycle.
- Back-to-back requests: the next request is sampled in IDLE at cycle 2W+4, giving a throughput of one word per 2W+4 cycles.
- Strobes and `SRAM_ADDR` are registered outputs with no combinational path from inputs; only `ready` is combinational.

## Structure
- A shared package `sram_ctrl_pkg` holds:
  - the state encoding (IDLE/LO/HI/DONE, 2 bits);
  - SRAM widths (ADDR 18, DATA 16);
  - the default `ADDR_OFFSET`.
- The wait counter is `$clog2(WAIT_CYCLES+1)` bits, minimum 1.
- No sub-module: one FSM plus the counter and the datapath registers. A tri-state DQ driver is inferred inline.

## Test plan
- W=1, write `0xDEADBEEF` @1024 → SRAM model holds `0xBEEF` at addr 0 and `0xDEAD` at addr 1; `ready` low cycles 0–4, high cycle 5.
- Read @1024 after the write → `read_data=0xDEADBEEF` in cycle 5; `OE_N` low cycles 1–4; DQ never driven by the DUT.
- Write `0x12345678` @1028, then read @1028 requested immediately after `ready` → second access samples at cycle 6; `read_data=0x12345678` at cycle 11; SRAM addrs 2/3 used.
- `wr_en=rd_en=1` @1032 with data `0xA5A5A5A5` → SRAM addrs 4/5 = `0xA5A5`; `read_data` keeps its prior value.
- `rst` pulsed in cycle 3 (HI phase of a write) → next cycle `WE_N=OE_N=CE_N=1`, DQ Z, `ready=1`, `read_data=0`; a following read @1024 completes normally.
- W=0, read @1024 → `ready` low cycles 0–2, high cycle 3 with correct data.
